// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor: 4-bit lookahead groups feeding a
// flat group-carry lookahead unit, with valid/ready handshakes on both sides.
module cla_addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = WIDTH / GROUP;

  if (GROUP != 4) begin : g_bad_group
    $error("cla_addsub_pipe: GROUP must be 4");
  end
  if ((WIDTH % GROUP) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("cla_addsub_pipe: WIDTH must be a multiple of GROUP in 4..64");
  end
  if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
    $error("cla_addsub_pipe: STAGES must be 1 or 2");
  end

  // Group generate and per-bit carry into each bit assuming group carry-in 0.
  function automatic logic grp_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  function automatic logic [3:0] grp_prefix_gen(input logic [3:0] g, input logic [3:0] p);
    logic [3:0] c;
    c[0] = 1'b0;
    c[1] = g[0];
    c[2] = g[1] | (p[1] & g[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]);
    return c;
  endfunction

  function automatic logic [3:0] grp_prefix_prop(input logic [3:0] p);
    logic [3:0] q;
    q[0] = 1'b1;
    q[1] = p[0];
    q[2] = p[1] & p[0];
    q[3] = p[2] & p[1] & p[0];
    return q;
  endfunction

  logic [WIDTH-1:0] w_beff, w_g, w_p, w_gpre;
  logic [NG-1:0]    w_pg, w_gg;
  logic             w_c0;

  always_comb begin
    w_beff = b ^ {WIDTH{sub}};
    w_g    = a & w_beff;
    w_p    = a ^ w_beff;
    w_c0   = sub | cin;
    w_pg   = '0;
    w_gg   = '0;
    w_gpre = '0;
    for (int k = 0; k < NG; k++) begin
      w_pg[k] = &w_p[k*4 +: 4];
      w_gg[k] = grp_gen(w_g[k*4 +: 4], w_p[k*4 +: 4]);
      w_gpre[k*4 +: 4] = grp_prefix_gen(w_g[k*4 +: 4], w_p[k*4 +: 4]);
    end
  end

  logic [NG-1:0]    w_s_pg, w_s_gg;
  logic [WIDTH-1:0] w_s_p, w_s_gpre;
  logic             w_s_c0;
  logic             w_accept, w_ld_out;
  logic             r_v2;

  assign w_accept = in_valid & in_ready;

  if (STAGES == 2) begin : g_two
    logic             r_v1;
    logic [NG-1:0]    r_pg, r_gg;
    logic [WIDTH-1:0] r_p, r_gpre;
    logic             r_c0;

    assign w_ld_out = r_v1 & (~r_v2 | out_ready);
    assign in_ready = ~r_v1 | w_ld_out;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v1   <= 1'b0;
        r_pg   <= '0;
        r_gg   <= '0;
        r_p    <= '0;
        r_gpre <= '0;
        r_c0   <= 1'b0;
      end else begin
        if (w_accept)      r_v1 <= 1'b1;
        else if (w_ld_out) r_v1 <= 1'b0;
        // Data only moves with an accepted beat, so idle X operands never enter.
        if (w_accept) begin
          r_pg   <= w_pg;
          r_gg   <= w_gg;
          r_p    <= w_p;
          r_gpre <= w_gpre;
          r_c0   <= w_c0;
        end
      end
    end

    assign w_s_pg   = r_pg;
    assign w_s_gg   = r_gg;
    assign w_s_p    = r_p;
    assign w_s_gpre = r_gpre;
    assign w_s_c0   = r_c0;
  end else begin : g_one
    assign w_ld_out = w_accept;
    assign in_ready = ~r_v2 | out_ready;
    assign w_s_pg   = w_pg;
    assign w_s_gg   = w_gg;
    assign w_s_p    = w_p;
    assign w_s_gpre = w_gpre;
    assign w_s_c0   = w_c0;
  end

  logic [NG:0]      w_cg;
  logic [WIDTH-1:0] w_cb, w_sum;
  logic             w_cout, w_ovf, w_zero;
  logic             t_acc, t_term;

  // Each group carry is a flat sum of products over all lower groups.
  always_comb begin
    w_cg    = '0;
    w_cg[0] = w_s_c0;
    t_acc   = 1'b0;
    t_term  = 1'b0;
    for (int k = 1; k <= NG; k++) begin
      t_acc = w_s_c0;
      for (int m = 0; m < k; m++) t_acc = t_acc & w_s_pg[m];
      for (int j = 0; j < k; j++) begin
        t_term = w_s_gg[j];
        for (int m = j + 1; m < k; m++) t_term = t_term & w_s_pg[m];
        t_acc = t_acc | t_term;
      end
      w_cg[k] = t_acc;
    end
  end

  always_comb begin
    w_cb = '0;
    for (int k = 0; k < NG; k++) begin
      w_cb[k*4 +: 4] = w_s_gpre[k*4 +: 4]
                     | (grp_prefix_prop(w_s_p[k*4 +: 4]) & {4{w_cg[k]}});
    end
    w_sum  = w_s_p ^ w_cb;
    w_cout = w_cg[NG];
    w_ovf  = w_cb[WIDTH-1] ^ w_cg[NG];
    w_zero = ~|w_sum;
  end

  logic [WIDTH-1:0] r_sum;
  logic             r_cout, r_ovf, r_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2   <= 1'b0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      if (w_ld_out)       r_v2 <= 1'b1;
      else if (out_ready) r_v2 <= 1'b0;
      if (w_ld_out) begin
        r_sum  <= w_sum;
        r_cout <= w_cout;
        r_ovf  <= w_ovf;
        r_zero <= w_zero;
      end
    end
  end

  assign out_valid = r_v2;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe: directed vectors, stall/reset sequences on a default
// instance, and randomized traffic on six WIDTH/STAGES configurations.
module tb_cla_addsub_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic and the sign rule for overflow.
  function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                input logic cin, input logic sub,
                                output logic [63:0] s, output logic co,
                                output logic ov, output logic z);
    logic [64:0] mask, t;
    logic [63:0] am, bm;
    mask = (65'd1 << w) - 65'd1;
    am   = a & mask[63:0];
    bm   = (sub ? ~b : b) & mask[63:0];
    t    = {1'b0, am} + {1'b0, bm} + (sub ? 65'd1 : {64'd0, cin});
    s    = t[63:0] & mask[63:0];
    co   = t[w];
    ov   = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
    z    = (s == 64'd0);
  endfunction

  // ---------------- default instance for directed tests ----------------
  logic        d_in_valid = 1'b0, d_out_ready = 1'b1, d_cin = 1'b0, d_sub = 1'b0;
  logic [31:0] d_a = '0, d_b = '0;
  logic        d_in_ready, d_out_valid, d_cout, d_ovf, d_zero;
  logic [31:0] d_sum;

  cla_addsub_pipe #(.WIDTH(32), .GROUP(4), .STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .a(d_a), .b(d_b), .cin(d_cin), .sub(d_sub),
    .out_valid(d_out_valid), .out_ready(d_out_ready),
    .sum(d_sum), .cout(d_cout), .ovf(d_ovf), .zero(d_zero)
  );

  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub;
    logic [31:0] s;
    logic        co, ov, z;
  } vec_t;

  vec_t vecs[10];

  // ---------------- randomized multi-config instances ----------------
  logic        r_in_valid = 1'b0, r_out_ready = 1'b1, r_cin = 1'b0, r_sub = 1'b0;
  logic [63:0] r_a = '0, r_b = '0;
  bit          rnd_on = 1'b0, phase_b = 1'b0, end_chk = 1'b0;

  typedef struct {
    logic [63:0] s;
    logic        co, ov, z;
    int          t;
    bit          nostall;
  } exp_t;

  for (genvar ci = 0; ci < 6; ci++) begin : g_cfg
    localparam int W = (ci % 3 == 0) ? 8 : ((ci % 3 == 1) ? 32 : 64);
    localparam int S = (ci < 3) ? 1 : 2;
    logic         w_ir, w_ov, w_co, w_of, w_z;
    logic [W-1:0] w_s;
    exp_t         q[$];
    int           cnt = 0;

    cla_addsub_pipe #(.WIDTH(W), .GROUP(4), .STAGES(S)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(r_in_valid), .in_ready(w_ir),
      .a(r_a[W-1:0]), .b(r_b[W-1:0]), .cin(r_cin), .sub(r_sub),
      .out_valid(w_ov), .out_ready(r_out_ready),
      .sum(w_s), .cout(w_co), .ovf(w_of), .zero(w_z)
    );

    always @(negedge clk) begin
      exp_t        e;
      logic [63:0] ms;
      logic        mco, mov, mz;
      if (rnd_on) begin
        if (w_ov && r_out_ready) begin
          check($sformatf("rnd_have_expected_w%0d_s%0d", W, S), 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check($sformatf("rnd_sum_w%0d_s%0d", W, S), 64'(w_s), e.s);
            check($sformatf("rnd_cout_w%0d_s%0d", W, S), 64'(w_co), 64'(e.co));
            check($sformatf("rnd_ovf_w%0d_s%0d", W, S), 64'(w_of), 64'(e.ov));
            check($sformatf("rnd_zero_w%0d_s%0d", W, S), 64'(w_z), 64'(e.z));
            if (e.nostall)
              check($sformatf("rnd_latency_w%0d_s%0d", W, S), 64'(cnt - e.t), 64'(S));
          end
        end
        if (r_in_valid && w_ir) begin
          model(W, r_a, r_b, r_cin, r_sub, ms, mco, mov, mz);
          e.s = ms; e.co = mco; e.ov = mov; e.z = mz;
          e.t = cnt; e.nostall = phase_b;
          q.push_back(e);
        end
        if (end_chk)
          check($sformatf("rnd_drained_w%0d_s%0d", W, S), 64'(q.size()), 64'd0);
      end
      cnt++;
    end
  end

  // ---------------- directed helpers ----------------
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(posedge clk); #1;
    d_a = v.a; d_b = v.b; d_cin = v.cin; d_sub = v.sub;
    d_in_valid = 1'b1; d_out_ready = 1'b1;
    @(negedge clk);
    check($sformatf("vec%0d_in_ready", idx), 64'(d_in_ready), 64'd1);
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (d_out_valid) begin
        lat = i;
        break;
      end
    end
    check($sformatf("vec%0d_latency", idx), 64'(lat), 64'd2);
    if (lat != 0) begin
      check($sformatf("vec%0d_sum", idx), 64'(d_sum), 64'(v.s));
      check($sformatf("vec%0d_cout", idx), 64'(d_cout), 64'(v.co));
      check($sformatf("vec%0d_ovf", idx), 64'(d_ovf), 64'(v.ov));
      check($sformatf("vec%0d_zero", idx), 64'(d_zero), 64'(v.z));
    end
  endtask

  task automatic run_stall_stream();
    int  acc, got, stall_left, t;
    bit  stalled, hs_in;
    int  pop_t[4];
    pop_t = '{0, 0, 0, 0};
    acc = 0; got = 0; stall_left = 0; t = 0; stalled = 1'b0;
    @(posedge clk); #1;
    d_out_ready = 1'b1; d_sub = 1'b0; d_cin = 1'b0;
    d_a = 32'd1; d_b = 32'd1; d_in_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      t++;
      if (d_out_valid && !d_out_ready) begin
        check("stall_sum_hold", 64'(d_sum), 64'd2);
        if (stall_left == 3) begin
          check("stall_in_ready_low", 64'(d_in_ready), 64'd0);
          check("stall_beats_held", 64'(acc), 64'd2);
        end
      end
      hs_in = d_in_valid && d_in_ready;
      if (d_out_valid && d_out_ready) begin
        check("stream_order_sum", 64'(d_sum), 64'(2 * (got + 1)));
        pop_t[got] = t;
        got++;
      end
      if (hs_in) acc++;
      @(posedge clk); #1;
      if (hs_in) begin
        if (acc < 4) begin
          d_a = 32'(acc + 1);
          d_b = 32'(acc + 1);
        end else begin
          d_in_valid = 1'b0;
        end
      end
      if (!stalled && d_out_valid) begin
        stalled = 1'b1;
        stall_left = 3;
        d_out_ready = 1'b0;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) d_out_ready = 1'b1;
      end
    end
    d_in_valid = 1'b0;
    check("stream_count", 64'(got), 64'd4);
    for (int i = 1; i < 4; i++)
      check($sformatf("stream_gap%0d", i), 64'(pop_t[i] - pop_t[i-1]), 64'd1);
  endtask

  task automatic run_reset_flush();
    int ghost;
    @(posedge clk); #1;
    d_out_ready = 1'b0; d_sub = 1'b0; d_cin = 1'b0;
    d_a = 32'd10; d_b = 32'd20; d_in_valid = 1'b1;
    @(posedge clk); #1;
    d_a = 32'd30; d_b = 32'd40;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_out_valid", 64'(d_out_valid), 64'd1);
    check("rst_pre_in_ready", 64'(d_in_ready), 64'd0);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_out_valid", 64'(d_out_valid), 64'd0);
    check("rst_async_sum", 64'(d_sum), 64'd0);
    check("rst_async_flags", 64'({d_cout, d_ovf, d_zero}), 64'd0);
    check("rst_async_in_ready", 64'(d_in_ready), 64'd1);
    #2 rst_n = 1'b1;
    d_out_ready = 1'b1;
    ghost = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (d_out_valid) ghost++;
    end
    check("rst_no_ghost_beats", 64'(ghost), 64'd0);
    check("rst_in_ready_after", 64'(d_in_ready), 64'd1);
  endtask

  task automatic rnd_cycle(input bit rand_ready);
    @(posedge clk); #1;
    r_in_valid = ($urandom_range(0, 3) != 0);
    r_a = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0:       r_b = ~r_a;
      1:       r_b = r_a;
      2:       r_b = 64'd1;
      default: r_b = {$urandom, $urandom};
    endcase
    r_cin = 1'($urandom_range(0, 1));
    r_sub = 1'($urandom_range(0, 1));
    r_out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{32'h0000_0003, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};

    #1;
    check("reset_out_valid", 64'(d_out_valid), 64'd0);
    check("reset_sum", 64'(d_sum), 64'd0);
    check("reset_flags", 64'({d_cout, d_ovf, d_zero}), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", 64'(d_in_ready), 64'd1);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);
    repeat (2) @(posedge clk);
    run_stall_stream();
    repeat (2) @(posedge clk);
    run_reset_flush();

    @(posedge clk); #1;
    rnd_on = 1'b1;
    for (int i = 0; i < 10000; i++) rnd_cycle(1'b1);
    @(posedge clk); #1;
    r_in_valid = 1'b0; r_out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 phase_b = 1'b1;
    for (int i = 0; i < 10000; i++) rnd_cycle(1'b0);
    @(posedge clk); #1;
    r_in_valid = 1'b0; r_out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 end_chk = 1'b1;
    @(posedge clk); #1 end_chk = 1'b0;
    rnd_on = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cla_addsub_pipe.md
Name: cla_addsub_pipe

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups with a second-level group-carry lookahead unit. It replaces single-group 4-bit adders in the datapath wherever wide add/sub with status flags is needed, such as the ALU and branch-target paths. Operands enter and results leave through valid/ready handshakes, so the block can sit between elastic pipeline stages.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of GROUP, range 4..64.
GROUP, 4, bits per lookahead group; fixed at 4 in this generation (elaboration error otherwise).
STAGES, 2, pipeline register stages, 1 or 2; any other value is an elaboration error.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  operand beat valid.
in_ready  out  1  block can accept a beat this cycle.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
cin  in  1  carry-in; used only when sub=0.
sub  in  1  0 = add, 1 = subtract.
out_valid  out  1  result beat valid.
out_ready  in  1  downstream accepts the result.
sum  out  WIDTH  result.
cout  out  1  carry out of MSB (for sub: 1 = no borrow).
ovf  out  1  two's-complement signed overflow.
zero  out  1  sum == 0.

Behaviour:
- Operation: sub=0 gives a + b + cin; sub=1 gives a + ~b + 1 (cin ignored). Effective B is b ^ {WIDTH{sub}}; effective carry-in is sub ? 1 : cin. Sum is taken modulo 2^WIDTH.
- Per-bit terms: g=a&b', p=a^b'.
- Each group produces group propagate PG and group generate GG.
- Group carries: c[k+1] = GG[k] | PG[k]&c[k]; must be computed as lookahead terms, not a ripple chain across groups.
- Flags:
  - cout = final carry.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = ~|sum.
- STAGES=2:
  - Stage 1 registers PG/GG per group, the per-bit p, the effective carry-in, and the MSB-carry-in prerequisites.
  - Stage 2 registers sum and the flags.
- STAGES=1: all logic sits before a single output register.
- Latency: a beat accepted at edge N presents out_valid=1 after edge N+STAGES, provided no stall.
- Handshake:
  - Beat transfers on the input when in_valid & in_ready.
  - Result transfers on the output when out_valid & out_ready.
  - Each stage holds a valid bit. A stage loads when it is empty or when its downstream stage drains in the same cycle.
  - in_ready = ~v1 | (stage-1 advances this cycle). in_ready may combinationally depend on out_ready.
  - Full throughput: 1 beat/cycle when out_ready stays high.
- Stall: while out_valid & ~out_ready, sum/cout/ovf/zero hold stable and out_valid stays high. Each stage holds up to one beat; no beat is dropped or duplicated, and order is preserved.
- Simultaneous accept and drain on a full pipe: allowed; occupancy is unchanged.
- in_valid=0: upstream stages go empty. Data registers may hold stale values, but out_valid must be 0 when the output stage is empty.
- Reset (rst_n low, asynchronous):
  - All stage valid bits clear immediately; out_valid=0 and sum/cout/ovf/zero=0.
  - in_ready=1 once out of reset.
  - In-flight beats are discarded and never emitted after release.
- Deassertion of rst_n is assumed synchronised externally.
- No X must propagate to outputs when in_valid=0 with X operands.

Test Plan:
1. Default params, a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0, out_ready=1 -> two edges after accept: sum=0x00000000, cout=1, ovf=0, zero=1.
2. a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, ovf=1, cout=0. Then a=0x00000005, b=0x00000007, sub=1, cin=1 -> sum=0xFFFFFFFE, cout=0, ovf=0 (cin ignored).
3. a=0x80000000, b=0x00000001, sub=1 -> sum=0x7FFFFFFF, ovf=1, cout=1, zero=0.
4. Stream beats 1+1, 2+2, 3+3, 4+4 back-to-back; hold out_ready=0 for 3 cycles after the first out_valid:
   - in_ready drops after 2 beats are held.
   - sum stays 0x2 during the stall.
   - After release, results emerge 0x2, 0x4, 0x6, 0x8 in order, one per cycle.
5. Two beats in flight, pulse rst_n low mid-cycle -> out_valid falls asynchronously without waiting for a clock edge. After release, no result appears until new input; in_ready=1.
6. Sweep WIDTH in {8, 32, 64} and STAGES in {1, 2} with 10k random beats and random out_ready -> every sum/cout/ovf/zero matches the reference model; latency equals STAGES when there is no stall.
